// File: rtl/key_pkg.sv
// Shared types and 50 MHz timing defaults for the key event generator.
package key_pkg;

  localparam int unsigned NUM_KEYS_DEF      = 2;
  localparam int unsigned DEBOUNCE_DEF      = 500000;
  localparam int unsigned REPEAT_DELAY_DEF  = 25000000;
  localparam int unsigned REPEAT_PERIOD_DEF = 6250000;
  localparam int unsigned CNT_W_DEF         = 26;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    HELD         = 3'd2,
    REPEATING    = 3'd3,
    RELEASE_WAIT = 3'd4
  } key_state_e;

  // Registered per-channel results handed to the top level
  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic evt;
  } key_ch_out_t;

endpackage

// File: rtl/key_event_gen_if.sv
// Button inputs, arm control and conditioned pulse outputs of the key event generator.
interface key_event_gen_if #(
  parameter int unsigned NUM_KEYS = 2
);

  logic [NUM_KEYS-1:0] key_n;
  logic                arm;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] press_pulse;
  logic [NUM_KEYS-1:0] release_pulse;
  logic [NUM_KEYS-1:0] event_pulse;

  modport master (
    output key_n, arm,
    input  key_level, press_pulse, release_pulse, event_pulse
  );

  modport slave (
    input  key_n, arm,
    output key_level, press_pulse, release_pulse, event_pulse
  );

endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce/auto-repeat FSM with a shared
// counter, and registered level and pulse outputs gated by arm.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        key_n,
  input  logic        arm,
  input  logic        repeat_en,
  output key_ch_out_t ch_out
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [1:0]       sync_q;
  logic             key_s;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             from_rep_q, from_rep_d;
  logic             press_c, release_c, rpt_c;
  logic             press_q, release_q, event_q;

  // Sync flops hold the raw active-low level, so reset means "released"
  assign key_s = ~sync_q[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q     <= 2'b11;
      state_q    <= IDLE;
      cnt_q      <= '0;
      level_q    <= 1'b0;
      from_rep_q <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      event_q    <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], key_n};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      from_rep_q <= from_rep_d;
      press_q    <= press_c & arm;
      release_q  <= release_c & arm;
      event_q    <= (press_c | rpt_c) & arm;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    level_d    = level_q;
    from_rep_d = from_rep_q;
    press_c    = 1'b0;
    release_c  = 1'b0;
    rpt_c      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (key_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          level_d = 1'b1;
          press_c = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!key_s) begin
          state_d    = RELEASE_WAIT;
          cnt_d      = CNT_W'(1);
          from_rep_d = 1'b0;
        end else if (repeat_en) begin
          if (cnt_q == RD_LAST) begin
            state_d = REPEATING;
            rpt_c   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      REPEATING: begin
        if (!key_s) begin
          state_d    = RELEASE_WAIT;
          cnt_d      = CNT_W'(1);
          from_rep_d = 1'b1;
        end else if (cnt_q == RP_LAST) begin
          rpt_c = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to pressed resumes the hold with a fresh repeat phase
        if (key_s) begin
          state_d = from_rep_q ? REPEATING : HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d   = IDLE;
          level_d   = 1'b0;
          release_c = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    ch_out.level = level_q;
    ch_out.press = press_q;
    ch_out.rel   = release_q;
    ch_out.evt   = event_q;
  end

endmodule

// File: rtl/key_event_gen.sv
// Pushbutton conditioner: one debounce/auto-repeat channel per key, with arm
// gating and per-key repeat enables applied at the channel boundary.
module key_event_gen
  import key_pkg::*;
#(
  parameter int unsigned         NUM_KEYS        = NUM_KEYS_DEF,
  parameter int unsigned         DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int unsigned         REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned         REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
  parameter logic [NUM_KEYS-1:0] REPEAT_MASK     = NUM_KEYS'(2'b10),
  parameter int unsigned         CNT_W           = CNT_W_DEF
) (
  input logic           clock,
  input logic           reset,
  key_event_gen_if.slave bus
);

  key_ch_out_t         ch_out [NUM_KEYS];
  logic [NUM_KEYS-1:0] level_v, press_v, release_v, event_v;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clock     (clock),
      .reset     (reset),
      .key_n     (bus.key_n[i]),
      .arm       (bus.arm),
      .repeat_en (REPEAT_MASK[i]),
      .ch_out    (ch_out[i])
    );
  end

  always_comb begin
    level_v   = '0;
    press_v   = '0;
    release_v = '0;
    event_v   = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      level_v[i]   = ch_out[i].level;
      press_v[i]   = ch_out[i].press;
      release_v[i] = ch_out[i].rel;
      event_v[i]   = ch_out[i].evt;
    end
  end

  assign bus.key_level     = level_v;
  assign bus.press_pulse   = press_v;
  assign bus.release_pulse = release_v;
  assign bus.event_pulse   = event_v;

endmodule

// File: tb/tb_key_event_gen.sv
// Scoreboard bench for key_event_gen with short debounce/repeat timing.
module tb_key_event_gen;

  localparam int unsigned NK = 2;
  localparam int unsigned DB = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 3;
  localparam logic [NK-1:0] MASK = 2'b10;

  typedef struct {
    int cyc;
    int key;
    int kind;  // 0 press, 1 release, 2 repeat
  } exp_t;

  typedef struct {
    int key;
    int s;     // first edge sampling key_n low
    int e;     // first edge sampling key_n high again
    bit chk;
  } ivl_t;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sbq[$];
  ivl_t ivq[$];
  logic [NK-1:0] lvl_exp = '0;

  always #5 clock = ~clock;

  key_event_gen_if #(.NUM_KEYS(NK)) bus ();

  key_event_gen #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .REPEAT_MASK     (MASK),
    .CNT_W           (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
  endtask

  // Expected pulse times for one clean press held over edges s..e-1
  function automatic void push_exp(input int k, input int s, input int e);
    int p;
    p = s + int'(DB) + 1;
    sbq.push_back('{p, k, 0});
    sbq.push_back('{e + int'(DB) + 1, k, 1});
    if (MASK[k])
      for (int t = p + int'(RD); t < e + 2; t += int'(RP)) sbq.push_back('{t, k, 2});
  endfunction

  task automatic hold_key(input int k, input int s, input int e, input bit chk);
    ivq.push_back('{k, s, e, chk});
    if (chk) push_exp(k, s, e);
  endtask

  // Drive key_n for the next edge, step one clock, then score all outputs
  task automatic tick();
    logic [NK-1:0] kn, ep, er, ev;
    logic arm_now;
    kn = '1;
    foreach (ivq[j])
      if (ivq[j].s <= cyc + 1 && cyc + 1 < ivq[j].e) kn[ivq[j].key] = 1'b0;
    bus.key_n = kn;
    arm_now = bus.arm;
    @(posedge clock);
    cyc++;
    #1;
    ep = '0; er = '0; ev = '0;
    for (int j = sbq.size() - 1; j >= 0; j--) begin
      if (sbq[j].cyc == cyc) begin
        case (sbq[j].kind)
          0: begin ep[sbq[j].key] = arm_now; ev[sbq[j].key] = arm_now; lvl_exp[sbq[j].key] = 1'b1; end
          1: begin er[sbq[j].key] = arm_now; lvl_exp[sbq[j].key] = 1'b0; end
          default: ev[sbq[j].key] = arm_now;
        endcase
        sbq.delete(j);
      end
    end
    check_eq("press_pulse", 32'(bus.press_pulse), 32'(ep));
    check_eq("release_pulse", 32'(bus.release_pulse), 32'(er));
    check_eq("event_pulse", 32'(bus.event_pulse), 32'(ev));
    check_eq("key_level", 32'(bus.key_level), 32'(lvl_exp));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Reset wipes all pending events; keys still held are re-accepted as new presses
  task automatic do_reset(input int n);
    int s2;
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      sbq.delete();
      lvl_exp = '0;
      tick();
    end
    reset = 1'b0;
    sbq.delete();
    lvl_exp = '0;
    foreach (ivq[j]) begin
      s2 = (ivq[j].s > cyc + 1) ? ivq[j].s : cyc + 1;
      if (ivq[j].chk && ivq[j].e - s2 >= int'(DB)) push_exp(ivq[j].key, s2, ivq[j].e);
    end
  endtask

  initial begin
    int c;
    bus.key_n = '1;
    bus.arm   = 1'b1;
    reset     = 1'b1;
    do_reset(2);
    run(3);

    // Single clean press on a non-repeating key
    c = cyc;
    hold_key(0, c + 2, c + 14, 1'b1);
    run(30);

    // Bounce shorter than the debounce window never produces an event
    c = cyc;
    for (int i = 0; i < 5; i++) hold_key(0, c + 2 + 4 * i, c + 4 + 4 * i, 1'b0);
    run(30);

    // Long hold on the repeating key: press, delay, then periodic repeats
    c = cyc;
    hold_key(1, c + 2, c + 32, 1'b1);
    run(45);

    // Both keys pressed on the same edge; key 0 held long without repeats
    c = cyc;
    hold_key(0, c + 2, c + 32, 1'b1);
    hold_key(1, c + 2, c + 10, 1'b1);
    run(45);

    // Pulses dropped while disarmed, repeats resume once armed
    c = cyc;
    bus.arm = 1'b0;
    hold_key(1, c + 2, c + 40, 1'b1);
    run(12);
    bus.arm = 1'b1;
    run(45);

    // Reset in the middle of PRESS_WAIT with the key still held
    c = cyc;
    hold_key(0, c + 2, c + 30, 1'b1);
    run(4);
    do_reset(1);
    run(40);

    // Reset in the middle of HELD with the key still held
    c = cyc;
    hold_key(1, c + 2, c + 45, 1'b1);
    run(15);
    do_reset(1);
    run(45);

    run(10);
    check_eq("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
